// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one req/gnt/rvalid memory port between the
// instruction-fetch and data ports. Responses are routed back through an
// in-order FIFO of requester IDs.
module mem_port_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned ARB_MODE        = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        resp_err_o
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);

  typedef enum logic {
    ID_INSTR = 1'b0,
    ID_DATA  = 1'b1
  } req_id_e;

  logic [CW-1:0]              count_q, count_d;
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [MAX_OUTSTANDING-1:0] id_fifo_q, id_fifo_d;
  logic                       lock_q, lock_d;
  req_id_e                    lock_id_q, lock_id_d;
  req_id_e                    last_q, last_d;

  req_id_e sel_id;
  req_id_e head_id;
  logic    sel_req;
  logic    accept;
  logic    pop;

  // Requester selection: a pending lock overrides arbitration.
  always_comb begin
    sel_id = ID_INSTR;
    if (lock_q) begin
      sel_id = lock_id_q;
    end else if (instr_req_i && data_req_i) begin
      if (ARB_MODE == 1) begin
        sel_id = ID_DATA;
      end else begin
        sel_id = (last_q == ID_DATA) ? ID_INSTR : ID_DATA;
      end
    end else if (data_req_i) begin
      sel_id = ID_DATA;
    end
  end

  // Shared-port request mux, grant split and response routing.
  always_comb begin
    sel_req   = (sel_id == ID_DATA) ? data_req_i : instr_req_i;
    mem_req_o = sel_req && (count_q < MAX_CNT);
    accept    = mem_req_o && mem_gnt_i;

    if (sel_id == ID_DATA) begin
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_addr_o  = data_addr_i;
      mem_wdata_o = data_wdata_i;
    end else begin
      mem_we_o    = 1'b0;
      mem_be_o    = '1;
      mem_addr_o  = instr_addr_i;
      mem_wdata_o = '0;
    end

    instr_gnt_o = accept && (sel_id == ID_INSTR);
    data_gnt_o  = accept && (sel_id == ID_DATA);

    pop            = mem_rvalid_i && (count_q != '0);
    head_id        = req_id_e'(id_fifo_q[rd_ptr_q]);
    instr_rvalid_o = pop && (head_id == ID_INSTR);
    data_rvalid_o  = pop && (head_id == ID_DATA);
    resp_err_o     = mem_rvalid_i && (count_q == '0);
    instr_rdata_o  = mem_rdata_i;
    data_rdata_o   = mem_rdata_i;
  end

  // Next state for the ID FIFO, occupancy count, lock and last-granted side.
  always_comb begin
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    id_fifo_d = id_fifo_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    last_d    = last_q;

    if (accept) begin
      id_fifo_d[wr_ptr_q] = sel_id;
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
      last_d   = sel_id;
      lock_d   = 1'b0;
    end else if (mem_req_o) begin
      lock_d    = 1'b1;
      lock_id_d = sel_id;
    end

    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
    end

    case ({accept, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; last_q resets to data so instr wins the first tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      id_fifo_q <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= ID_INSTR;
      last_q    <= ID_DATA;
    end else begin
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      id_fifo_q <= id_fifo_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      last_q    <= last_d;
    end
  end

endmodule
